mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be:
- ADDR_WIDTH, default 32, address width.
- DATA_WIDTH, default 32, data width.
- MEM_LATENCY, default 2, memory read latency in cycles; legal range 1-15.

REQ-002 Ports SHALL be (name, direction, width, meaning), clock and reset first:
- clk, in, 1, sole clock; all state updates on its rising edge.
- rst_n, in, 1, asynchronous, active-low reset.
- i_req, in, 1, instruction-fetch read request.
- i_addr, in, ADDR_WIDTH, fetch address.
- i_ack, out, 1, fetch completion pulse.
- i_rdata, out, DATA_WIDTH, fetched word.
- d_req, in, 1, data-access request.
- d_we, in, 1, 1 = store, 0 = load.
- d_addr, in, ADDR_WIDTH, data address.
- d_wdata, in, DATA_WIDTH, store data.
- d_ack, out, 1, data completion pulse.
- d_rdata, out, DATA_WIDTH, load data.
- mem_en, out, 1, memory access strobe.
- mem_we, out, 1, memory write enable.
- mem_addr, out, ADDR_WIDTH, memory address.
- mem_wdata, out, DATA_WIDTH, memory write data.
- mem_rdata, in, DATA_WIDTH, memory read data, valid MEM_LATENCY cycles after the mem_en cycle.

Function
REQ-003 The block SHALL implement a four-state FSM: IDLE, ISSUE, WAIT, RESP.

REQ-004 IDLE:
- On a rising edge with i_req or d_req high, latch the winning requester's address, we and wdata (we forced 0 for the instruction port), record the owner, go to ISSUE.
- Otherwise stay in IDLE.

REQ-005 Arbitration SHALL be round-robin:
- One request pending: grant it.
- Both pending: grant the port not granted last.
- The last-grant register updates on every grant.

REQ-006 ISSUE SHALL last exactly one cycle:
- mem_en=1; mem_we/mem_addr/mem_wdata come from the latched values.
- Next state is RESP if the latched access is a write, WAIT if it is a read.

REQ-007 WAIT SHALL last exactly MEM_LATENCY cycles:
- A down-counter (at least 4 bits) is loaded on entry.
- mem_rdata is captured into the owner's rdata register on the final WAIT edge.
- Next state is RESP.

REQ-008 RESP SHALL last exactly one cycle:
- Assert the owner's ack (i_ack or d_ack) only.
- Next state is IDLE unconditionally; requests are not sampled on this edge.

REQ-009 Latency from the edge that grants the request SHALL be:
- Write: ack 2 cycles later.
- Read: ack MEM_LATENCY+2 cycles later.

REQ-010 Output timing:
- i_rdata/d_rdata SHALL hold their captured value until overwritten by the next read for that port.
- Stores SHALL leave d_rdata unchanged.

REQ-011 Outside ISSUE:
- mem_en and mem_we SHALL be 0.
- mem_addr and mem_wdata SHALL hold their last values.

REQ-012 Request hold rule:
- A requester SHALL hold req and its payload stable until its ack.
- req still high in the cycle after ack SHALL be treated as a new request.

REQ-013 Request-drop rule: a req dropped before its ack and after the grant SHALL NOT abort the transaction; the ack is still issued.

REQ-014 i_ack and d_ack SHALL never be high in the same cycle and SHALL each be high for at most one consecutive cycle.

REQ-015 Only one transaction SHALL be outstanding at any time.

Reset
REQ-016 rst_n low SHALL asynchronously force:
- state = IDLE;
- mem_en, mem_we, i_ack, d_ack = 0;
- mem_addr, mem_wdata, i_rdata, d_rdata = 0;
- counter = 0;
- last-grant = data port, so the instruction port wins the first contention.

REQ-017 Reset asserted mid-transaction SHALL abandon it with no ack issued. After rst_n rises, the first edge SHALL be treated as an IDLE edge.

Verification
REQ-018 Single fetch, MEM_LATENCY=2:
- Stimulus: i_req=1, i_addr=0x100, memory returns 0xDEADBEEF.
- Response: mem_en=1 with mem_addr=0x100 one cycle after the grant edge; i_ack=1 with i_rdata=0xDEADBEEF four cycles after the grant edge; d_ack stays 0.

REQ-019 Store:
- Stimulus: d_req=1, d_we=1, d_addr=0x40, d_wdata=0x12345678.
- Response: one ISSUE cycle with mem_we=1, mem_addr=0x40, mem_wdata=0x12345678; d_ack two cycles after the grant edge; d_rdata unchanged.

REQ-020 Contention after reset:
- Stimulus: i_req and d_req both held high.
- Response: grant order I, D, I, D; acks alternate; no cycle has both acks high.

REQ-021 Back-to-back:
- Stimulus: d_req held high for three loads, MEM_LATENCY=1.
- Response: three d_ack pulses spaced exactly 4 cycles apart.

REQ-022 Reset mid-WAIT:
- Stimulus: rst_n driven low during WAIT of a read.
- Response: outputs zero immediately; no ack; after release, a new i_req completes normally.

REQ-023 MEM_LATENCY=15:
- Stimulus: a single load.
- Response: d_ack arrives exactly 17 cycles after the grant edge, and the captured data matches mem_rdata in the 15th cycle after mem_en.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the shared memory port.
`timescale 1ns/1ps
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  i_req;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic                  i_ack;
  logic [DATA_WIDTH-1:0] i_rdata;
  logic                  d_req;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic                  d_ack;
  logic [DATA_WIDTH-1:0] d_rdata;
  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_ack, i_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  // Requester and memory side
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-outstanding memory port between
// an instruction-fetch port and a load/store port.
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_LATENCY = 2
) (
  input logic           clk,
  input logic           rst_n,
  mem_port_arbiter_if.slave bus
);
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  last_gnt_q, last_gnt_d;  // 1 = data port
  logic                  owner_q, owner_d;        // 1 = data port
  logic                  gnt_data;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_we_q, mem_we_d;
  logic                  i_ack_q, i_ack_d;
  logic                  d_ack_q, d_ack_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_gnt_q  <= 1'b1;
      owner_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_gnt_q  <= last_gnt_d;
      owner_q     <= owner_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  // Next-state and registered-output decode; strobes and acks default low.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_gnt_d  = last_gnt_q;
    owner_d     = owner_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    // Data wins unless both request and data had the previous grant.
    gnt_data    = bus.d_req & ~(bus.i_req & last_gnt_q);

    case (state_q)
      IDLE: begin
        if (bus.i_req | bus.d_req) begin
          owner_d    = gnt_data;
          last_gnt_d = gnt_data;
          mem_en_d   = 1'b1;
          mem_we_d   = gnt_data & bus.d_we;
          mem_addr_d = gnt_data ? bus.d_addr : bus.i_addr;
          if (gnt_data) mem_wdata_d = bus.d_wdata;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_we_q) begin
          i_ack_d = ~owner_q;
          d_ack_d = owner_q;
          state_d = RESP;
        end else begin
          cnt_d   = CNT_W'(MEM_LATENCY);
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        // Final wait edge: memory data is valid now.
        if (cnt_q == CNT_W'(1)) begin
          if (owner_q) d_rdata_d = bus.mem_rdata;
          else         i_rdata_d = bus.mem_rdata;
          i_ack_d = ~owner_q;
          d_ack_d = owner_q;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.i_ack     = i_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter at memory latencies 2, 1 and 15.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam logic [31:0] GARBAGE = 32'h0BAD_F00D;

  typedef struct {
    int          dut;
    bit          port_d;
    logic [31:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [2:0]  ireq, dreq, dwe, iack, dack, men, mwe;
  logic [31:0] iaddr[3], daddr[3], dwdata[3];
  logic [31:0] irdata[3], drdata[3], maddr[3], mwdata[3];
  logic [31:0] ird_m[3], drd_m[3];
  logic [2:0]  pi, pd;
  exp_t        sb[$];
  exp_t        got_e;
  int          ack_times[$];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] memdata(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEAD_BEEF : {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
    mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(LAT)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    assign bus.i_req   = ireq[g];
    assign bus.i_addr  = iaddr[g];
    assign bus.d_req   = dreq[g];
    assign bus.d_we    = dwe[g];
    assign bus.d_addr  = daddr[g];
    assign bus.d_wdata = dwdata[g];
    assign iack[g]     = bus.i_ack;
    assign dack[g]     = bus.d_ack;
    assign irdata[g]   = bus.i_rdata;
    assign drdata[g]   = bus.d_rdata;
    assign men[g]      = bus.mem_en;
    assign mwe[g]      = bus.mem_we;
    assign maddr[g]    = bus.mem_addr;
    assign mwdata[g]   = bus.mem_wdata;

    // Memory model: read data valid only in the LAT-th cycle after mem_en.
    int          rem;
    logic [31:0] ma, rd_q;
    always @(negedge clk) begin
      if (!rst_n) begin
        rem  <= 0;
        rd_q <= GARBAGE;
      end else begin
        rd_q <= (rem == 1) ? memdata(ma) : GARBAGE;
        if (bus.mem_en && !bus.mem_we) begin
          rem <= LAT;
          ma  <= bus.mem_addr;
        end else if (rem > 0) begin
          rem <= rem - 1;
        end
      end
    end
    assign bus.mem_rdata = rd_q;
  end

  // Ack monitor: pops the scoreboard on every ack pulse.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (iack[k] | dack[k]) begin
        chk("both_acks", 64'(iack[k] & dack[k]), 64'd0);
        chk("ack_one_cycle", 64'((iack[k] & pi[k]) | (dack[k] & pd[k])), 64'd0);
        chk("ack_expected", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          got_e = sb.pop_front();
          chk("ack_dut", 64'(k), 64'(got_e.dut));
          chk("ack_port", 64'(dack[k]), 64'(got_e.port_d));
          chk("ack_rdata", 64'(dack[k] ? drdata[k] : irdata[k]), 64'(got_e.rdata));
        end
      end
    end
    pi <= iack;
    pd <= dack;
  end

  task automatic expect_txn(input int k, input bit port_d, input bit we, input logic [31:0] addr);
    exp_t x;
    x.dut    = k;
    x.port_d = port_d;
    if (we) begin
      x.rdata = drd_m[k];
    end else begin
      x.rdata = memdata(addr);
      if (port_d) drd_m[k] = x.rdata;
      else        ird_m[k] = x.rdata;
    end
    sb.push_back(x);
  endtask

  task automatic issue(input int k, input bit port_d, input bit we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (port_d) begin
      dreq[k] = 1'b1; dwe[k] = we; daddr[k] = addr; dwdata[k] = wdata;
    end else begin
      ireq[k] = 1'b1; iaddr[k] = addr;
    end
    expect_txn(k, port_d, we, addr);
  endtask

  task automatic drop_all();
    ireq = '0; dreq = '0; dwe = '0;
  endtask

  // Counts rising edges (starting at n0) until num acks are seen on DUT k.
  task automatic wait_acks(input int k, input int num, input int n0);
    int n, got;
    n = n0; got = 0;
    ack_times.delete();
    while (got < num && n < n0 + 200) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (iack[k] | dack[k]) begin
        ack_times.push_back(n);
        got++;
      end
    end
    chk("ack_count", 64'(got), 64'(num));
  endtask

  function automatic int at(input int i);
    return (i < ack_times.size()) ? ack_times[i] : -1;
  endfunction

  task automatic chk_zero(input int k);
    chk("rst_mem_en", 64'(men[k]), 64'd0);
    chk("rst_mem_we", 64'(mwe[k]), 64'd0);
    chk("rst_i_ack", 64'(iack[k]), 64'd0);
    chk("rst_d_ack", 64'(dack[k]), 64'd0);
    chk("rst_mem_addr", 64'(maddr[k]), 64'd0);
    chk("rst_mem_wdata", 64'(mwdata[k]), 64'd0);
    chk("rst_i_rdata", 64'(irdata[k]), 64'd0);
    chk("rst_d_rdata", 64'(drdata[k]), 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drop_all();
    sb.delete();
    for (int k = 0; k < 3; k++) begin
      ird_m[k] = '0;
      drd_m[k] = '0;
    end
    #1;
    for (int k = 0; k < 3; k++) chk_zero(k);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    drop_all();
    for (int k = 0; k < 3; k++) begin
      iaddr[k] = '0; daddr[k] = '0; dwdata[k] = '0;
    end
    @(negedge clk);
    do_reset();

    // Single fetch
    issue(0, 1'b0, 1'b0, 32'h100, 32'h0);
    @(posedge clk); @(negedge clk);
    chk("fetch_mem_en", 64'(men[0]), 64'd1);
    chk("fetch_mem_we", 64'(mwe[0]), 64'd0);
    chk("fetch_mem_addr", 64'(maddr[0]), 64'h100);
    wait_acks(0, 1, 1);
    chk("fetch_latency", 64'(at(0)), 64'd4);
    chk("fetch_rdata", 64'(irdata[0]), 64'hDEAD_BEEF);
    drop_all();
    @(negedge clk);
    chk("idle_mem_en", 64'(men[0]), 64'd0);
    chk("idle_addr_hold", 64'(maddr[0]), 64'h100);

    // Store
    issue(0, 1'b1, 1'b1, 32'h40, 32'h1234_5678);
    @(posedge clk); @(negedge clk);
    chk("store_mem_en", 64'(men[0]), 64'd1);
    chk("store_mem_we", 64'(mwe[0]), 64'd1);
    chk("store_mem_addr", 64'(maddr[0]), 64'h40);
    chk("store_mem_wdata", 64'(mwdata[0]), 64'h1234_5678);
    wait_acks(0, 1, 1);
    chk("store_latency", 64'(at(0)), 64'd2);
    drop_all();
    @(negedge clk);
    chk("post_store_we", 64'(mwe[0]), 64'd0);
    chk("wdata_hold", 64'(mwdata[0]), 64'h1234_5678);

    // Load then store: the store must not disturb d_rdata
    issue(0, 1'b1, 1'b0, 32'h44, 32'h0);
    wait_acks(0, 1, 0);
    chk("load_latency", 64'(at(0)), 64'd4);
    drop_all();
    @(negedge clk);
    issue(0, 1'b1, 1'b1, 32'h48, 32'hCAFE_0001);
    wait_acks(0, 1, 0);
    chk("store2_latency", 64'(at(0)), 64'd2);
    chk("store_keeps_rdata", 64'(drdata[0]), 64'(memdata(32'h44)));
    drop_all();
    @(negedge clk);

    // Request dropped after grant still completes
    issue(0, 1'b0, 1'b0, 32'h700, 32'h0);
    @(posedge clk); @(negedge clk);
    ireq[0] = 1'b0;
    wait_acks(0, 1, 1);
    chk("drop_latency", 64'(at(0)), 64'd4);
    @(negedge clk);

    // Reset during WAIT abandons the read
    issue(0, 1'b0, 1'b0, 32'h800, 32'h0);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    do_reset();
    issue(0, 1'b0, 1'b0, 32'h900, 32'h0);
    wait_acks(0, 1, 0);
    chk("post_reset_latency", 64'(at(0)), 64'd4);
    drop_all();
    @(negedge clk);

    // Contention after reset: I, D, I, D
    do_reset();
    issue(0, 1'b0, 1'b0, 32'h500, 32'h0);
    issue(0, 1'b1, 1'b0, 32'h600, 32'h0);
    expect_txn(0, 1'b0, 1'b0, 32'h500);
    expect_txn(0, 1'b1, 1'b0, 32'h600);
    wait_acks(0, 4, 0);
    drop_all();
    chk("rr_ack0", 64'(at(0)), 64'd4);
    chk("rr_ack1", 64'(at(1)), 64'd9);
    chk("rr_ack2", 64'(at(2)), 64'd14);
    chk("rr_ack3", 64'(at(3)), 64'd19);
    @(negedge clk);

    // Back-to-back loads at latency 1
    issue(1, 1'b1, 1'b0, 32'h1000, 32'h0);
    expect_txn(1, 1'b1, 1'b0, 32'h1000);
    expect_txn(1, 1'b1, 1'b0, 32'h1000);
    wait_acks(1, 3, 0);
    drop_all();
    chk("b2b_ack0", 64'(at(0)), 64'd3);
    chk("b2b_ack1", 64'(at(1)), 64'd7);
    chk("b2b_ack2", 64'(at(2)), 64'd11);
    @(negedge clk);

    // Maximum latency
    issue(2, 1'b1, 1'b0, 32'h2000, 32'h0);
    wait_acks(2, 1, 0);
    drop_all();
    chk("lat15_latency", 64'(at(0)), 64'd17);
    chk("lat15_rdata", 64'(drdata[2]), 64'(memdata(32'h2000)));
    @(negedge clk);
    @(negedge clk);

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
